// File: rtl/module_nonansi_mc_fifo.sv
// Purpose: NCH independent DEPTH x WIDTH queues drained through one shared output by round-robin arbitration.
// Latency: 1 cycle from a push into an empty queue to the entry appearing on out_data.
// Backpressure: in_ready[c] drops when queue c is full; a stalled output locks its grant until accepted.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready   per-channel write handshake, in_data channel c at [c*WIDTH +: WIDTH]
//   out_valid/out_ready shared output handshake; out_data is the head of the granted queue, out_ch its index
//   level               per-channel occupancy, channel c at [c*(AW+1) +: AW+1]
module module_nonansi_mc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int NCH   = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   clk, rst, in_valid, in_ready, in_data,
   out_valid, out_ready, out_data, out_ch, level
);
   input  logic                    clk;
   input  logic                    rst;
   input  logic [NCH-1:0]          in_valid;
   output logic [NCH-1:0]          in_ready;
   input  logic [NCH*WIDTH-1:0]    in_data;
   output logic                    out_valid;
   input  logic                    out_ready;
   output logic [WIDTH-1:0]        out_data;
   output logic [CW-1:0]           out_ch;
   output logic [NCH*(AW+1)-1:0]   level;

   logic [WIDTH-1:0] mem   [NCH][DEPTH];
   logic [AW:0]      count [NCH];
   logic [AW-1:0]    wptr  [NCH];
   logic [AW-1:0]    rptr  [NCH];
   logic [CW-1:0]    rr_ptr;
   logic             lock;
   logic [CW-1:0]    locked_ch;

   logic [CW-1:0]    sel;
   logic [CW-1:0]    next_rr;
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   pop;
   logic [NCH-1:0]   nonempty;

   // Space is judged on registered occupancy only, so a full queue never
   // accepts a write even if it is being drained in the same cycle.
   always_comb begin
      in_ready = '0;
      push     = '0;
      nonempty = '0;
      level    = '0;
      for (int c = 0; c < NCH; c++) begin
         in_ready[c] = !rst && (count[c] != (AW+1)'(DEPTH));
         push[c]     = in_valid[c] && in_ready[c];
         nonempty[c] = (count[c] != '0);
         level[c*(AW+1) +: AW+1] = count[c];
      end
   end

   // Grant: the locked channel if a stall is pending, otherwise the first
   // non-empty channel at or after rr_ptr.
   always_comb begin
      int  idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      sel   = '0;
      if (lock) begin
         sel = locked_ch;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_ptr) + i) % NCH;
            if (!found && nonempty[idx]) begin
               sel   = CW'(idx);
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      out_valid = |nonempty;
      out_data  = '0;
      out_ch    = '0;
      pop       = '0;
      next_rr   = (sel == CW'(NCH-1)) ? '0 : sel + 1'b1;
      if (out_valid) begin
         out_data = mem[sel][rptr[sel]];
         out_ch   = (NCH == 1) ? '0 : sel;
      end
      for (int c = 0; c < NCH; c++) begin
         pop[c] = out_valid && out_ready && (sel == CW'(c));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            count[c] <= '0;
            wptr[c]  <= '0;
            rptr[c]  <= '0;
         end
         rr_ptr    <= '0;
         lock      <= 1'b0;
         locked_ch <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (push[c]) wptr[c] <= wptr[c] + 1'b1;
            if (pop[c])  rptr[c] <= rptr[c] + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
            else if (!push[c] && pop[c]) count[c] <= count[c] - 1'b1;
         end
         if (out_valid && out_ready) begin
            lock   <= 1'b0;
            rr_ptr <= next_rr;
         end else if (out_valid) begin
            // Freeze the grant so out_data/out_ch stay put until accepted.
            lock      <= 1'b1;
            locked_ch <= sel;
         end
      end
   end

   // Storage carries no reset; unread entries are never exposed because
   // out_data is forced to zero when nothing is valid.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (push[c]) mem[c][wptr[c]] <= in_data[c*WIDTH +: WIDTH];
      end
   end

endmodule

// File: tb/tb_module_nonansi_mc_fifo.sv
module tb_module_nonansi_mc_fifo;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [0:0]  out_ch;
   logic [5:0]  level;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one queue per channel plus grant bookkeeping.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit         m_lock;
   int         m_lch;
   int         m_rr;
   logic [8:0] obs[$];   // {out_ch, out_data} observed at each accepted pop

   module_nonansi_mc_fifo #(.WIDTH(8), .DEPTH(4), .NCH(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ch(out_ch), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic int msize(input int c);
      return (c == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [7:0] mhead(input int c);
      return (c == 0) ? q0[0] : q1[0];
   endfunction

   function automatic int msel();
      if (m_lock) return m_lch;
      for (int i = 0; i < 2; i++) begin
         if (msize((m_rr + i) % 2) > 0) return (m_rr + i) % 2;
      end
      return -1;
   endfunction

   task automatic check_all();
      int s;
      s = msel();
      chk("out_valid", out_valid, (s >= 0));
      chk("out_ch",    out_ch,    (s >= 0) ? s : 0);
      chk("out_data",  out_data,  (s >= 0) ? mhead(s) : 8'h00);
      chk("level",     level,     msize(0) + msize(1) * 8);
      chk("in_ready",  in_ready,  rst ? 0 : ((msize(0) != 4) ? 1 : 0) + ((msize(1) != 4) ? 2 : 0));
   endtask

   // One clock: drive inputs, advance the model with the same inputs, then compare.
   task automatic cyc(input logic r, input logic [1:0] v, input logic [7:0] d0,
                      input logic [7:0] d1, input logic ordy);
      int  s;
      bit  ps0, ps1;
      rst = r; in_valid = v; in_data = {d1, d0}; out_ready = ordy;
      #1;
      if (r) chk("rst_in_ready", in_ready, 0);
      if (!r && out_valid && ordy) obs.push_back({out_ch, out_data});
      @(posedge clk);
      if (r) begin
         q0.delete(); q1.delete();
         m_lock = 0; m_lch = 0; m_rr = 0;
      end else begin
         s   = msel();
         ps0 = v[0] && (q0.size() != 4);
         ps1 = v[1] && (q1.size() != 4);
         if (s >= 0 && ordy) begin
            if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            m_lock = 0;
            m_rr   = (s + 1) % 2;
         end else if (s >= 0) begin
            m_lock = 1;
            m_lch  = s;
         end
         if (ps0) q0.push_back(d0);
         if (ps1) q1.push_back(d1);
      end
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
      m_lock = 0; m_lch = 0; m_rr = 0;

      // Reset, then idle.
      cyc(1, 2'b00, 0, 0, 0);
      cyc(1, 2'b00, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 2'b00, 0, 0, 0);
      chk("idle_ready", in_ready, 2'b11);

      // Fill ch0 with output stalled; a fifth push is dropped.
      cyc(0, 2'b01, 8'h11, 0, 0);
      chk("lvl1", level[2:0], 1);
      cyc(0, 2'b01, 8'h22, 0, 0);
      cyc(0, 2'b01, 8'h33, 0, 0);
      cyc(0, 2'b01, 8'h44, 0, 0);
      chk("full_lvl", level[2:0], 4);
      chk("full_rdy", in_ready[0], 0);
      cyc(0, 2'b01, 8'h55, 0, 0);
      chk("drop_lvl", level[2:0], 4);
      chk("hold_data", out_data, 8'h11);
      for (int i = 0; i < 4; i++) cyc(0, 2'b00, 0, 0, 1);
      chk("drain_order", {obs[0][7:0], obs[1][7:0], obs[2][7:0], obs[3][7:0]}, 32'h11223344);

      // Round-robin between two filled channels.
      cyc(1, 2'b00, 0, 0, 0);
      obs.delete();
      cyc(0, 2'b11, 8'hA0, 8'hB0, 0);
      cyc(0, 2'b11, 8'hA1, 8'hB1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 2'b00, 0, 0, 1);
      chk("rr0", obs[0], {1'b0, 8'hA0});
      chk("rr1", obs[1], {1'b1, 8'hB0});
      chk("rr2", obs[2], {1'b0, 8'hA1});
      chk("rr3", obs[3], {1'b1, 8'hB1});
      chk("rr_empty", out_valid, 0);

      // Grant lock holds ch1 while ch0 (higher priority) fills.
      cyc(1, 2'b00, 0, 0, 0);
      cyc(0, 2'b10, 0, 8'hB0, 0);
      cyc(0, 2'b01, 8'hA0, 0, 0);
      cyc(0, 2'b00, 0, 0, 0);
      cyc(0, 2'b00, 0, 0, 0);
      chk("lock_ch", out_ch, 1);
      chk("lock_data", out_data, 8'hB0);
      cyc(0, 2'b00, 0, 0, 1);
      chk("after_lock_data", out_data, 8'hA0);
      chk("after_lock_ch", out_ch, 0);

      // Push and pop together at count 1, then pointer wrap.
      cyc(1, 2'b00, 0, 0, 0);
      cyc(0, 2'b01, 8'h55, 0, 0);
      cyc(0, 2'b01, 8'h66, 0, 1);
      chk("pp_lvl", level[2:0], 1);
      chk("pp_data", out_data, 8'h66);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 2'b01, 8'h70 + 8'(i), 0, 1);
         chk("wrap_data", out_data, 8'h70 + i);
         chk("wrap_lvl", level[2:0], 1);
      end

      // Mid-stream reset with a simultaneous push.
      cyc(1, 2'b00, 0, 0, 0);
      cyc(0, 2'b01, 8'hC1, 0, 0);
      cyc(0, 2'b01, 8'hC2, 0, 0);
      cyc(0, 2'b01, 8'hC3, 0, 0);
      cyc(1, 2'b01, 8'hEE, 0, 1);
      chk("rst_lvl", level, 0);
      chk("rst_vld", out_valid, 0);
      cyc(0, 2'b00, 0, 0, 0);
      chk("rst_nopush", out_valid, 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 99) == 0), 2'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
